// File: rtl/scope_pkg.sv
// scope_pkg: shared state encoding, header constants and source ids for the scope TX arbiter.
package scope_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
  localparam logic [3:0] HDR_MAGIC = 4'hA;
  localparam logic [7:0] TERM_BYTE = 8'hEE;
  localparam logic SRC_SCOPE = 1'b0;
  localparam logic SRC_LA    = 1'b1;
  localparam int LP_SEND_LEN = 1008;
  function automatic logic [7:0] hdr_byte(input logic id);
    return {HDR_MAGIC, 3'b000, id};
  endfunction
endpackage

// File: rtl/scope_tx_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; the pointer moves to the other source after each frame.
module rr_arb2
  import scope_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       cur,
  output logic       pick
);
  logic ptr;
  always_comb pick = (req == 2'b11) ? ptr : req[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= SRC_SCOPE;
    else if (adv) ptr <= ~cur;
endmodule

// File: rtl/scope_tx_arbiter.sv
// scope_tx_arbiter: shares the UDP byte-stream TX path between the scope and LA frame sources,
// prepending a 2-byte header and enforcing frame length, start timeout and inter-frame gap.
module scope_tx_arbiter
  import scope_pkg::*;
#(
  parameter int P_MAX_LEN       = LP_SEND_LEN,
  parameter int P_START_TIMEOUT = 4096,
  parameter int P_GAP           = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant,
  input  logic [7:0] i_src0_data,
  input  logic       i_src0_vld,
  input  logic       i_src0_last,
  input  logic [7:0] i_src1_data,
  input  logic       i_src1_vld,
  input  logic       i_src1_last,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_vld,
  output logic       o_tx_last,
  output logic       o_frame_err,
  output logic       o_drop
);
  localparam int CW = $clog2(P_MAX_LEN + 1);
  localparam int TW = $clog2(P_START_TIMEOUT + 1);
  localparam int GW = $clog2(P_GAP + 1);
  localparam logic [CW-1:0] LEN_END = CW'(P_MAX_LEN - 1);
  localparam logic [TW-1:0] TMO_END = TW'(P_START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_END = GW'(P_GAP - 1);
  logic [2:0] state;
  logic id, pick, adv, gvld, glast;
  logic [1:0] vld;
  logic [7:0] seq, gdata;
  logic [CW-1:0] len_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  always_comb begin
    vld = {i_src1_vld, i_src0_vld};
    gvld = vld[id] & o_grant[id];
    glast = id ? i_src1_last : i_src0_last;
    gdata = id ? i_src1_data : i_src0_data;
    adv = (state == S_GAP) && (gap_cnt == GAP_END);
  end
  rr_arb2 u_arb (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .req  (i_req),
    .adv  (adv),
    .cur  (id),
    .pick (pick)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= S_IDLE;
      id <= SRC_SCOPE;
      seq <= '0;
      len_cnt <= '0;
      tmo_cnt <= '0;
      gap_cnt <= '0;
      o_grant <= '0;
      o_tx_data <= '0;
      o_tx_vld <= 1'b0;
      o_tx_last <= 1'b0;
      o_frame_err <= 1'b0;
      o_drop <= 1'b0;
    end else begin
      o_drop <= |(vld & ~o_grant);
      o_tx_vld <= 1'b0;
      o_tx_last <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        S_IDLE: if (i_tx_ready && |i_req) begin
          id <= pick;
          o_tx_data <= hdr_byte(pick);
          o_tx_vld <= 1'b1;
          state <= S_HDR0;
        end
        S_HDR0: begin
          o_tx_data <= seq;
          o_tx_vld <= 1'b1;
          state <= S_HDR1;
        end
        S_HDR1: begin
          seq <= seq + 8'd1;
          o_grant <= id ? 2'b10 : 2'b01;
          tmo_cnt <= '0;
          len_cnt <= '0;
          state <= S_WAIT;
        end
        S_WAIT, S_DATA: if (gvld) begin
          o_tx_data <= gdata;
          o_tx_vld <= 1'b1;
          len_cnt <= len_cnt + 1'b1;
          // a byte that fills the frame closes it even without last, flagged as an error
          if (glast || len_cnt == LEN_END) begin
            o_tx_last <= 1'b1;
            o_frame_err <= ~glast;
            o_grant <= '0;
            gap_cnt <= '0;
            state <= S_GAP;
          end else state <= S_DATA;
        end else if (state == S_WAIT) begin
          if (tmo_cnt == TMO_END) begin
            o_tx_data <= TERM_BYTE;
            o_tx_vld <= 1'b1;
            o_tx_last <= 1'b1;
            o_frame_err <= 1'b1;
            o_grant <= '0;
            gap_cnt <= '0;
            state <= S_GAP;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_END) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_scope_tx_arbiter.sv
// tb_scope_tx_arbiter: table-driven frames plus corner sequences, checked through an output-byte scoreboard.
module tb_scope_tx_arbiter;
  localparam int MAXL = 1008;
  localparam int TMO = 4096;
  localparam int GAPN = 16;
  typedef struct packed {logic [7:0] data; logic last;} exp_t;
  typedef struct {logic [1:0] req; int len; bit lst; logic id;} vec_t;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_tx_ready = 1'b1;
  logic [1:0] i_req = '0, o_grant;
  logic [7:0] i_src0_data = '0, i_src1_data = '0, o_tx_data;
  logic i_src0_vld = 1'b0, i_src0_last = 1'b0, i_src1_vld = 1'b0, i_src1_last = 1'b0;
  logic o_tx_vld, o_tx_last, o_frame_err, o_drop;
  exp_t q[$];
  exp_t e;
  vec_t tv[7];
  int errors = 0, checks = 0, n_err = 0, n_drop = 0, cyc = 0, last_cyc = -1, out_cyc = 0;
  int g, e0, d0;
  logic [7:0] seq_m = '0;
  always #5 i_clk = ~i_clk;
  scope_tx_arbiter #(.P_MAX_LEN(MAXL), .P_START_TIMEOUT(TMO), .P_GAP(GAPN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .o_grant(o_grant),
    .i_src0_data(i_src0_data), .i_src0_vld(i_src0_vld), .i_src0_last(i_src0_last),
    .i_src1_data(i_src1_data), .i_src1_vld(i_src1_vld), .i_src1_last(i_src1_last),
    .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data), .o_tx_vld(o_tx_vld),
    .o_tx_last(o_tx_last), .o_frame_err(o_frame_err), .o_drop(o_drop)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d, input logic l);
    q.push_back(exp_t'({d, l}));
  endtask
  task automatic drive(input logic id, input logic v, input logic [7:0] d, input logic l);
    if (id) begin i_src1_vld = v; i_src1_data = d; i_src1_last = l; end
    else begin i_src0_vld = v; i_src0_data = d; i_src0_last = l; end
  endtask
  task automatic start(input logic [1:0] req, input logic id, output int gc);
    bit ok;
    push({4'hA, 3'b000, id}, 1'b0);
    push(seq_m, 1'b0);
    seq_m = seq_m + 8'd1;
    i_req = req;
    ok = 0;
    gc = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge i_clk);
      #1;
      ok = (o_grant != 2'b00);
      gc = cyc;
    end
    chk("grant", {30'd0, o_grant}, id ? 32'd2 : 32'd1);
    i_req = 2'b00;
  endtask
  task automatic send(input logic id, input int n, input bit lst);
    logic [7:0] d;
    logic l;
    for (int k = 0; k < n; k++) begin
      tick();
      d = 8'(k + (id ? 32'h40 : 32'h0));
      l = lst && (k == n - 1);
      if (k == n / 2) chk("grant_hold", {30'd0, o_grant}, id ? 32'd2 : 32'd1);
      drive(id, 1'b1, d, l);
      if (k < MAXL) push(d, l || (k == MAXL - 1));
    end
    tick();
    drive(id, 1'b0, 8'h00, 1'b0);
  endtask
  task automatic drain(input int bound);
    for (int k = 0; k < bound && q.size() != 0; k++) begin
      @(negedge i_clk);
      #1;
    end
    chk("drain", q.size(), 0);
  endtask
  initial begin
    fork
      forever begin
        @(negedge i_clk);
        cyc++;
        if (o_frame_err) n_err++;
        if (o_drop) n_drop++;
        chk("grant_onehot", {31'd0, $countones(o_grant) <= 1}, 32'd1);
        if (o_tx_vld) begin
          out_cyc = cyc;
          if (last_cyc >= 0) begin
            chk("gap", {31'd0, (cyc - last_cyc) > GAPN}, 32'd1);
            last_cyc = -1;
          end
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %0h expected no byte (cycle %0d)", o_tx_data, cyc);
          end else begin
            e = q.pop_front();
            chk("tx_data", {24'd0, o_tx_data}, {24'd0, e.data});
            chk("tx_last", {31'd0, o_tx_last}, {31'd0, e.last});
          end
          if (o_tx_last) last_cyc = cyc;
        end
      end
    join_none
    tv[0] = '{2'b11, 4, 1'b1, 1'b0};
    tv[1] = '{2'b11, 4, 1'b1, 1'b1};
    tv[2] = '{2'b11, 3, 1'b1, 1'b0};
    tv[3] = '{2'b11, 3, 1'b1, 1'b1};
    tv[4] = '{2'b01, 1008, 1'b1, 1'b0};
    tv[5] = '{2'b10, 7, 1'b1, 1'b1};
    tv[6] = '{2'b01, 1, 1'b1, 1'b0};
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_grant", {30'd0, o_grant}, 0);
    chk("rst_vld", {31'd0, o_tx_vld}, 0);
    chk("rst_last", {31'd0, o_tx_last}, 0);
    chk("rst_data", {24'd0, o_tx_data}, 0);
    chk("rst_err", {31'd0, o_frame_err}, 0);
    chk("rst_drop", {31'd0, o_drop}, 0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      e0 = n_err;
      start(tv[i].req, tv[i].id, g);
      send(tv[i].id, tv[i].len, tv[i].lst);
      drain(200);
      chk("frame_err_none", n_err - e0, 0);
      chk("grant_released", {30'd0, o_grant}, 0);
    end
    e0 = n_err;
    d0 = n_drop;
    start(2'b01, 1'b0, g);
    send(1'b0, 1100, 1'b0);
    drain(200);
    repeat (4) tick();
    chk("overlen_err", n_err - e0, 1);
    chk("overlen_drops", n_drop - d0, 92);
    e0 = n_err;
    start(2'b10, 1'b1, g);
    push(8'hEE, 1'b1);
    drain(TMO + 200);
    chk("timeout_latency", out_cyc - g, TMO);
    chk("timeout_err", n_err - e0, 1);
    chk("timeout_grant_off", {30'd0, o_grant}, 0);
    d0 = n_drop;
    for (int i = 0; i < 250; i++) begin
      start(i[0] ? 2'b10 : 2'b01, i[0], g);
      if (i == 5) begin
        tick();
        drive(1'b0, 1'b1, 8'h55, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        send(1'b1, 2, 1'b1);
      end else send(i[0], 1, 1'b1);
      drain(200);
    end
    chk("inject_drop", n_drop - d0, 1);
    chk("seq_model_wrapped", {24'd0, seq_m}, 32'd3);
    start(2'b01, 1'b0, g);
    send(1'b0, 500, 1'b0);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", {30'd0, o_grant}, 0);
    chk("mid_rst_vld", {31'd0, o_tx_vld}, 0);
    chk("mid_rst_last", {31'd0, o_tx_last}, 0);
    chk("mid_rst_data", {24'd0, o_tx_data}, 0);
    chk("mid_rst_err", {31'd0, o_frame_err}, 0);
    chk("mid_rst_queue", q.size(), 0);
    seq_m = '0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    start(2'b01, 1'b0, g);
    send(1'b0, 3, 1'b1);
    drain(200);
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scope_tx_arbiter.md
Name: scope_tx_arbiter

Overview:
- Shares the single Ethernet/UDP byte-stream transmit path between two frame sources: source 0 is the scope frame stream (1008 bytes per frame) and source 1 is the logic-analyser frame stream.
- Uses request/grant to pick a source, prepends a 2-byte frame header, forwards the granted source's payload, and enforces the frame length and a start timeout.
- Sits between the scope/LA tops and the UDP transmit FIFO.

Parameters:
- P_MAX_LEN, 1008: maximum payload bytes per frame; a longer frame is forcibly terminated.
- P_START_TIMEOUT, 4096: cycles allowed after grant for the first payload byte to arrive.
- P_GAP, 16: idle cycles after each frame before the next arbitration.

Ports:
- i_clk  in  1  system clock; all logic in this single domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  2  per-source frame request (level; bit0 = scope, bit1 = LA).
- o_grant  out  2  one-hot grant; held until the frame ends.
- i_src0_data  in  8  scope payload byte.
- i_src0_vld  in  1  scope byte valid.
- i_src0_last  in  1  scope final byte.
- i_src1_data  in  8  LA payload byte.
- i_src1_vld  in  1  LA byte valid.
- i_src1_last  in  1  LA final byte.
- i_tx_ready  in  1  downstream can accept a new frame; sampled only in IDLE.
- o_tx_data  out  8  output byte.
- o_tx_vld  out  1  output byte valid; gaps within a frame are allowed.
- o_tx_last  out  1  final byte of the frame.
- o_frame_err  out  1  one-cycle pulse: overlength frame or start timeout.
- o_drop  out  1  one-cycle pulse: vld seen from a non-granted source.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = 0, sequence counter = 0, all counters 0.
- States: IDLE -> HDR0 -> HDR1 -> WAIT -> DATA -> GAP -> IDLE; WAIT -> GAP on timeout.
- IDLE:
  - Requires i_tx_ready=1 and i_req!=0.
  - Picks a source: if both request, the pointer's source wins; otherwise the single requester.
  - Latches the chosen id, then goes to HDR0.
- HDR0: emits byte {4'hA, 3'b0, id} with vld=1.
- HDR1: emits the 8-bit sequence counter with vld=1, then increments it (wraps 255 -> 0). Drives o_grant[id]=1 from the next cycle.
- WAIT:
  - Counts cycles; the first vld from the granted source enters DATA and forwards that byte.
  - If the count reaches P_START_TIMEOUT: emit a 1-byte terminator 8'hEE with vld=1 and last=1, pulse o_frame_err, go to GAP.
- DATA:
  - Each granted-source vld is registered to o_tx_data/o_tx_vld one cycle later (1-cycle latency); the payload count is incremented.
  - src last with vld ends the frame: o_tx_last accompanies that byte, the grant drops next cycle, go to GAP.
  - If the count reaches P_MAX_LEN without last, that byte carries o_tx_last=1 and o_frame_err pulses. The grant drops and further source bytes are discarded, with o_drop pulsing each cycle.
  - A last arriving before P_MAX_LEN is accepted as a short frame; no error.
- GAP:
  - o_grant=0, o_tx_vld=0 for P_GAP cycles.
  - The pointer moves to the other source after every frame, including timed-out frames.
- Non-granted vld in any state: the byte is discarded and o_drop pulses. The scope and LA tops are push-only and are expected to wait for grant.
- A request withdrawn before selection is ignored. A request withdrawn after grant does not end the frame; only last, overlength or timeout does.
- i_tx_ready deasserting mid-frame is ignored.
- Asynchronous reset mid-frame aborts immediately: outputs go to 0 with no partial last.
- o_grant is one-hot or zero, never 2'b11.

Decomposition:
- Shared package, scope_pkg:
  - state encoding;
  - header magic 4'hA and terminator 8'hEE;
  - source ids SRC_SCOPE=0, SRC_LA=1;
  - LP_SEND_LEN=1008.
- One natural sub-module, rr_arb2: a 2-way round-robin pick with pointer update. All other logic stays inline.

Test Plan:
- Scope only: req=01 with a 1008-byte ramp and last on byte 1008 -> 1010 output bytes: A0, 00, the ramp, last on byte 1010; grant=01 throughout; no err.
- Both requesting from reset: req=11 -> scope frame (A0, seq 00) first, then LA frame (A1, seq 01) after 16 idle cycles; the pointer alternates on the following two frames.
- Overlength: scope sends 1100 bytes with no last -> byte 1010 has last=1, o_frame_err pulses once, o_drop pulses 92 times.
- Timeout: req=10, LA never sends -> after 4096 WAIT cycles the output is A1, seq, EE (last=1), err pulses, then GAP and return to IDLE.
- Sequence wrap and drop: run 257 frames -> the header seq wraps to 00 on frame 257. Source-0 vld injected during a source-1 frame pulses o_drop and leaves the output unchanged.
- Reset mid-DATA: pull i_rst_n low at payload byte 500 -> all outputs 0 the same cycle; the first frame after release carries seq 00.
